// File: rtl/fwd_hazard_ctrl_if.sv
// Bundles the operand/destination compare inputs and the forwarding/stall outputs.
// The pipeline side drives the master modport; the controller takes the slave modport.
// Widths follow the same parameters as the controller they connect to.
interface fwd_hazard_ctrl_if #(
   parameter int NUM_SRC = 3,
   parameter int REG_W   = 4,
   parameter int CNT_W   = 16
);
   logic                       fwd_en;
   logic [NUM_SRC*REG_W-1:0]   src_addr;
   logic [NUM_SRC-1:0]         src_valid;
   logic [REG_W-1:0]           exe_dest;
   logic                       exe_wb_en;
   logic                       exe_mem_read;
   logic [REG_W-1:0]           mem_dest;
   logic                       mem_wb_en;
   logic [REG_W-1:0]           wb_dest;
   logic                       wb_wb_en;
   logic                       clr_cnt;
   logic [NUM_SRC*2-1:0]       sel_src;
   logic                       hazard_stall;
   logic [CNT_W-1:0]           stall_cycles;

   modport master (
      output fwd_en, src_addr, src_valid, exe_dest, exe_wb_en, exe_mem_read,
             mem_dest, mem_wb_en, wb_dest, wb_wb_en, clr_cnt,
      input  sel_src, hazard_stall, stall_cycles
   );

   modport slave (
      input  fwd_en, src_addr, src_valid, exe_dest, exe_wb_en, exe_mem_read,
             mem_dest, mem_wb_en, wb_dest, wb_wb_en, clr_cnt,
      output sel_src, hazard_stall, stall_cycles
   );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use / no-forward hazard stall for the ID/EXE boundary.
// Latency: selects and stall are combinational; extended hold adds EXTRA_STALL registered cycles.
// No backpressure of its own: hazard_stall is the backpressure it applies to IF/ID.
module fwd_hazard_ctrl #(
   parameter int NUM_SRC     = 3,
   parameter int REG_W       = 4,
   parameter int EXTRA_STALL = 0,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fwd_hazard_ctrl_if.slave     bus
);

   typedef enum logic {RUN, HOLD} state_t;

   state_t             state_q, state_d;
   logic [3:0]         hcnt_q, hcnt_d;
   logic               lu_det, nf_det, det;
   logic               stall_raw, stall;
   logic [NUM_SRC*2-1:0] sel;
   logic [CNT_W-1:0]   cnt_q;

   // Compare every valid source against the older-stage destinations.
   always_comb begin
      lu_det = 1'b0;
      nf_det = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.src_valid[i]) begin
            if (bus.exe_wb_en && bus.exe_dest == bus.src_addr[i*REG_W +: REG_W]) begin
               nf_det = 1'b1;
               if (bus.exe_mem_read) lu_det = 1'b1;
            end
            if (bus.mem_wb_en && bus.mem_dest == bus.src_addr[i*REG_W +: REG_W]) begin
               nf_det = 1'b1;
            end
         end
      end
      det = bus.fwd_en ? lu_det : nf_det;
   end

   // RUN stalls on detect; HOLD keeps the stall for EXTRA_STALL cycles after a load-use.
   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      stall_raw = 1'b0;
      case (state_q)
         RUN: begin
            stall_raw = det;
            if (bus.fwd_en && lu_det && (EXTRA_STALL > 0)) begin
               state_d = HOLD;
               hcnt_d  = 4'(EXTRA_STALL);
            end
         end
         HOLD: begin
            stall_raw = 1'b1;
            hcnt_d    = hcnt_q - 4'd1;
            if (hcnt_q == 4'd1) state_d = RUN;
         end
         default: begin
            state_d = RUN;
            hcnt_d  = 4'd0;
         end
      endcase
   end

   // Outputs are forced quiet while reset is held, whatever the inputs say.
   assign stall = stall_raw & ~rst;

   // Per-channel forwarding select; MEM is the younger result and wins over WB.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.fwd_en && bus.src_valid[i] && !stall && !rst) begin
            if (bus.mem_wb_en && bus.mem_dest == bus.src_addr[i*REG_W +: REG_W])
               sel[2*i +: 2] = 2'b01;
            else if (bus.wb_wb_en && bus.wb_dest == bus.src_addr[i*REG_W +: REG_W])
               sel[2*i +: 2] = 2'b10;
         end
      end
   end

   // State and hold counter; reset aborts any hold in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         hcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
      end
   end

   // Saturating stall-cycle counter; clear beats increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (bus.clr_cnt)
         cnt_q <= '0;
      else if (stall && (cnt_q != {CNT_W{1'b1}}))
         cnt_q <= cnt_q + 1'b1;
   end

   assign bus.sel_src      = sel;
   assign bus.hazard_stall = stall;
   assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench: two controller instances (short hold / 4-bit counter, long hold / 16-bit counter)
// share one set of stimulus; expected values are hand-derived per vector.
module tb_fwd_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl_if #(.NUM_SRC(3), .REG_W(4), .CNT_W(4))  ifa ();
   fwd_hazard_ctrl_if #(.NUM_SRC(3), .REG_W(4), .CNT_W(16)) ifb ();

   fwd_hazard_ctrl #(.NUM_SRC(3), .REG_W(4), .EXTRA_STALL(2), .CNT_W(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   fwd_hazard_ctrl #(.NUM_SRC(3), .REG_W(4), .EXTRA_STALL(4), .CNT_W(16)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   assign ifb.fwd_en       = ifa.fwd_en;
   assign ifb.src_addr     = ifa.src_addr;
   assign ifb.src_valid    = ifa.src_valid;
   assign ifb.exe_dest     = ifa.exe_dest;
   assign ifb.exe_wb_en    = ifa.exe_wb_en;
   assign ifb.exe_mem_read = ifa.exe_mem_read;
   assign ifb.mem_dest     = ifa.mem_dest;
   assign ifb.mem_wb_en    = ifa.mem_wb_en;
   assign ifb.wb_dest      = ifa.wb_dest;
   assign ifb.wb_wb_en     = ifa.wb_wb_en;
   assign ifb.clr_cnt      = ifa.clr_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      ifa.fwd_en       = 1'b1;
      ifa.src_addr     = '0;
      ifa.src_valid    = '0;
      ifa.exe_dest     = '0;
      ifa.exe_wb_en    = 1'b0;
      ifa.exe_mem_read = 1'b0;
      ifa.mem_dest     = '0;
      ifa.mem_wb_en    = 1'b0;
      ifa.wb_dest      = '0;
      ifa.wb_wb_en     = 1'b0;
      ifa.clr_cnt      = 1'b0;
   endtask

   // Move to just after the next rising edge, where inputs are changed.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      // Reset with hazardous inputs applied: outputs must stay quiet.
      rst = 1'b1;
      ifa.src_addr     = {4'd0, 4'd0, 4'd3};
      ifa.src_valid    = 3'b001;
      ifa.mem_dest     = 4'd3;
      ifa.mem_wb_en    = 1'b1;
      ifa.exe_dest     = 4'd3;
      ifa.exe_wb_en    = 1'b1;
      ifa.exe_mem_read = 1'b1;
      tick();
      @(negedge clk);
      check("rst_stall_a", ifa.hazard_stall, 0);
      check("rst_sel_a",   ifa.sel_src, 0);
      check("rst_cnt_a",   ifa.stall_cycles, 0);
      check("rst_stall_b", ifb.hazard_stall, 0);
      tick();
      idle();
      rst = 1'b0;

      // 1: MEM and WB both match src0 -> MEM wins.
      ifa.src_addr  = {4'd0, 4'd0, 4'd3};
      ifa.src_valid = 3'b001;
      ifa.mem_dest  = 4'd3; ifa.mem_wb_en = 1'b1;
      ifa.wb_dest   = 4'd3; ifa.wb_wb_en  = 1'b1;
      @(negedge clk);
      check("t1_sel",   ifa.sel_src, 6'b000001);
      check("t1_stall", ifa.hazard_stall, 0);

      // 2: WB-only match on channel 1, then channel invalid.
      tick(); idle();
      ifa.src_addr  = {4'd0, 4'd5, 4'd0};
      ifa.src_valid = 3'b010;
      ifa.wb_dest   = 4'd5; ifa.wb_wb_en = 1'b1;
      @(negedge clk);
      check("t2_sel_wb", ifa.sel_src, 6'b001000);
      tick();
      ifa.src_valid = 3'b000;
      @(negedge clk);
      check("t2_sel_invalid", ifa.sel_src, 0);

      // Register 0 forwards like any other; channels select independently.
      tick(); idle();
      ifa.src_addr  = {4'd0, 4'd9, 4'd4};
      ifa.src_valid = 3'b101;
      ifa.mem_dest  = 4'd0; ifa.mem_wb_en = 1'b1;
      ifa.wb_dest   = 4'd4; ifa.wb_wb_en  = 1'b1;
      @(negedge clk);
      check("multi_sel", ifa.sel_src, 6'b010010);

      // 3: load-use on src0=7; MEM also matches so selects show the gating.
      tick(); idle();
      ifa.src_addr     = {4'd0, 4'd0, 4'd7};
      ifa.src_valid    = 3'b001;
      ifa.exe_dest     = 4'd7; ifa.exe_wb_en = 1'b1; ifa.exe_mem_read = 1'b1;
      ifa.mem_dest     = 4'd7; ifa.mem_wb_en = 1'b1;
      @(negedge clk);
      check("t3_c0_stall_a", ifa.hazard_stall, 1);
      check("t3_c0_sel_a",   ifa.sel_src, 0);
      check("t3_c0_stall_b", ifb.hazard_stall, 1);
      tick();
      ifa.exe_wb_en = 1'b0; ifa.exe_mem_read = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         check($sformatf("t3_c%0d_stall_a", c), ifa.hazard_stall, 1);
         check($sformatf("t3_c%0d_sel_a", c),   ifa.sel_src, 0);
         tick();
      end
      @(negedge clk);
      check("t3_c3_stall_a", ifa.hazard_stall, 0);
      check("t3_c3_sel_a",   ifa.sel_src, 6'b000001);
      check("t3_cnt_a",      ifa.stall_cycles, 3);
      check("t3_c3_stall_b", ifb.hazard_stall, 1);
      check("t3_c3_sel_b",   ifb.sel_src, 0);
      tick();
      @(negedge clk);
      check("t3_c4_stall_b", ifb.hazard_stall, 1);
      tick();
      @(negedge clk);
      check("t3_c5_stall_b", ifb.hazard_stall, 0);
      check("t3_cnt_b",      ifb.stall_cycles, 5);
      check("t3_cnt_a_hold", ifa.stall_cycles, 3);

      // 4: stall-only mode follows det cycle by cycle.
      tick(); idle();
      ifa.fwd_en    = 1'b0;
      ifa.src_addr  = {4'd0, 4'd0, 4'd2};
      ifa.src_valid = 3'b001;
      ifa.mem_dest  = 4'd2; ifa.mem_wb_en = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("t4_mem_stall%0d", c), ifa.hazard_stall, 1);
         check($sformatf("t4_mem_sel%0d", c),   ifa.sel_src, 0);
         tick();
      end
      ifa.mem_wb_en = 1'b0;
      ifa.wb_dest   = 4'd2; ifa.wb_wb_en = 1'b1;
      @(negedge clk);
      check("t4_wb_stall", ifa.hazard_stall, 0);
      check("t4_wb_sel",   ifa.sel_src, 0);
      tick();
      ifa.wb_wb_en  = 1'b0;
      ifa.exe_dest  = 4'd2; ifa.exe_wb_en = 1'b1;
      @(negedge clk);
      check("t4_exe_nofwd_stall", ifa.hazard_stall, 1);
      tick();
      ifa.fwd_en = 1'b1;
      @(negedge clk);
      check("t4_exe_fwd_stall", ifa.hazard_stall, 0);
      check("t4_exe_fwd_sel",   ifa.sel_src, 0);
      check("t4_cnt_a",         ifa.stall_cycles, 6);
      check("t4_cnt_b",         ifb.stall_cycles, 8);

      // 5: saturation of the 4-bit counter, then clear while stalling.
      tick(); idle();
      ifa.clr_cnt = 1'b1;
      tick();
      ifa.clr_cnt = 1'b0;
      @(negedge clk);
      check("t5_clr_idle", ifa.stall_cycles, 0);
      ifa.fwd_en    = 1'b0;
      ifa.src_addr  = {4'd0, 4'd0, 4'd2};
      ifa.src_valid = 3'b001;
      ifa.mem_dest  = 4'd2; ifa.mem_wb_en = 1'b1;
      for (int c = 0; c < 20; c++) tick();
      @(negedge clk);
      check("t5_sat_a",   ifa.stall_cycles, 15);
      check("t5_cnt_b",   ifb.stall_cycles, 20);
      ifa.clr_cnt = 1'b1;
      tick();
      ifa.clr_cnt = 1'b0;
      @(negedge clk);
      check("t5_clr_a",     ifa.stall_cycles, 0);
      check("t5_clr_b",     ifb.stall_cycles, 0);
      check("t5_clr_stall", ifa.hazard_stall, 1);
      tick();
      @(negedge clk);
      check("t5_resume_a", ifa.stall_cycles, 1);

      // 6: reset in the second HOLD cycle of the long-hold instance.
      tick(); idle();
      ifa.src_addr     = {4'd0, 4'd0, 4'd7};
      ifa.src_valid    = 3'b001;
      ifa.exe_dest     = 4'd7; ifa.exe_wb_en = 1'b1; ifa.exe_mem_read = 1'b1;
      tick();
      idle();
      tick();
      @(negedge clk);
      check("t6_hold2_b", ifb.hazard_stall, 1);
      rst = 1'b1;
      #1;
      check("t6_rst_stall_b", ifb.hazard_stall, 0);
      check("t6_rst_cnt_b",   ifb.stall_cycles, 0);
      check("t6_rst_sel_b",   ifb.sel_src, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6_run_stall_b", ifb.hazard_stall, 0);
      check("t6_run_cnt_b",   ifb.stall_cycles, 0);
      tick();
      @(negedge clk);
      check("t6_run2_stall_b", ifb.hazard_stall, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
